// File: rtl/spine_vc_port.sv
// Multi-VC bidirectional spine port: per-VC FIFOs on the IN and OUT paths, round-robin onto one registered output each.
// Optional SPINE_PORT_BYPASS_EN: a flit arriving at an idle path skips its FIFO for 1-cycle latency.

module spine_vc_fifo #(
    parameter int DWIDTH = 8,
    parameter int DEPTH  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push_i,
    input  logic [DWIDTH-1:0] din_i,
    input  logic              pop_i,
    output logic [DWIDTH-1:0] dout_o,
    output logic              full_o,
    output logic              empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]       wr_q, rd_q;
    logic [DWIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (push_i) wr_q <= wr_q + (AW+1)'(1);
            if (pop_i)  rd_q <= rd_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_q[AW-1:0]] <= din_i;
    end

    assign dout_o  = mem_q[rd_q[AW-1:0]];
    assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign empty_o = (wr_q == rd_q);
endmodule

module spine_vc_path #(
    parameter int DWIDTH     = 8,
    parameter int FIFO_DEPTH = 8,
    parameter int NUM_VC     = 2,
    parameter int VCW        = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en_i,
    input  logic [DWIDTH-1:0] in_data_i,
    input  logic [VCW-1:0]    in_vc_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    output logic [DWIDTH-1:0] out_data_o,
    output logic [VCW-1:0]    out_vc_o,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [NUM_VC-1:0] full_o
);
    logic [NUM_VC-1:0]             vc_oh, push, pop, empty, full, gnt_oh;
    logic [NUM_VC-1:0][DWIDTH-1:0] dout;
    logic [DWIDTH-1:0]             sel_data;
    logic [VCW-1:0]                gnt;
    logic                          gnt_vld, accept, load_ok, byp;
    logic [DWIDTH-1:0]             data_q, data_d;
    logic [VCW-1:0]                vc_q, vc_d, last_q, last_d;
    logic                          valid_q, valid_d;

    // An out-of-range VC decodes to an all-zero one-hot and is never ready.
    always_comb begin
        for (int v = 0; v < NUM_VC; v++) vc_oh[v] = (in_vc_i == VCW'(v));
    end

    assign in_ready_o = en_i && (|vc_oh) && !(|(full & vc_oh));
    assign accept     = in_valid_i && in_ready_o;
    assign load_ok    = !valid_q || out_ready_i;

`ifdef SPINE_PORT_BYPASS_EN
    assign byp = accept && (&empty) && load_ok;
`else
    assign byp = 1'b0;
`endif

    always_comb begin
        int idx;
        idx     = 0;
        gnt_vld = 1'b0;
        gnt     = '0;
        for (int i = 0; i < NUM_VC; i++) begin
            idx = (int'(last_q) + 1 + i) % NUM_VC;
            for (int v = 0; v < NUM_VC; v++) begin
                if (!gnt_vld && v == idx && !empty[v]) begin
                    gnt_vld = 1'b1;
                    gnt     = VCW'(v);
                end
            end
        end
    end

    always_comb begin
        sel_data = '0;
        for (int v = 0; v < NUM_VC; v++) begin
            gnt_oh[v] = gnt_vld && (gnt == VCW'(v));
            pop[v]    = load_ok && gnt_oh[v];
            push[v]   = accept && vc_oh[v] && !byp;
            sel_data  = sel_data | (dout[v] & {DWIDTH{gnt_oh[v]}});
        end
    end

    for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
        spine_vc_fifo #(.DWIDTH(DWIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
            .clk     (clk),
            .reset   (reset),
            .push_i  (push[v]),
            .din_i   (in_data_i),
            .pop_i   (pop[v]),
            .dout_o  (dout[v]),
            .full_o  (full[v]),
            .empty_o (empty[v])
        );
    end

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        vc_d    = vc_q;
        last_d  = last_q;
        if (load_ok) begin
            if (byp) begin
                valid_d = 1'b1;
                data_d  = in_data_i;
                vc_d    = in_vc_i;
                last_d  = in_vc_i;
            end else if (gnt_vld) begin
                valid_d = 1'b1;
                data_d  = sel_data;
                vc_d    = gnt;
                last_d  = gnt;
            end else begin
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            vc_q    <= '0;
            last_q  <= VCW'(NUM_VC - 1);
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            vc_q    <= vc_d;
            last_q  <= last_d;
        end
    end

    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;
    assign out_vc_o    = vc_q;
    assign full_o      = full;
endmodule

module spine_vc_port #(
    parameter int   PORT_ID    = 0,
    parameter int   DWIDTH     = 8,
    parameter int   FIFO_DEPTH = 8,
    parameter int   NUM_VC     = 2,
    localparam int  VCW        = (NUM_VC > 1) ? $clog2(NUM_VC) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        dir_mode,
    input  logic [DWIDTH-1:0] in_incoming_data,
    input  logic [VCW-1:0]    in_incoming_vc,
    input  logic              in_incoming_valid,
    output logic              in_incoming_ready,
    output logic [DWIDTH-1:0] in_outgoing_data,
    output logic [VCW-1:0]    in_outgoing_vc,
    output logic              in_outgoing_valid,
    input  logic              in_outgoing_ready,
    input  logic [DWIDTH-1:0] out_incoming_data,
    input  logic [VCW-1:0]    out_incoming_vc,
    input  logic              out_incoming_valid,
    output logic              out_incoming_ready,
    output logic [DWIDTH-1:0] out_outgoing_data,
    output logic [VCW-1:0]    out_outgoing_vc,
    output logic              out_outgoing_valid,
    input  logic              out_outgoing_ready,
    output logic [NUM_VC-1:0] in_fifo_full,
    output logic [NUM_VC-1:0] out_fifo_full
);
    if (PORT_ID < 0 || NUM_VC < 1 || NUM_VC > 8 || FIFO_DEPTH < 2 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_param_err
        $error("spine_vc_port: illegal parameters");
    end

    spine_vc_path #(.DWIDTH(DWIDTH), .FIFO_DEPTH(FIFO_DEPTH), .NUM_VC(NUM_VC), .VCW(VCW)) u_in (
        .clk         (clk),
        .reset       (reset),
        .en_i        (dir_mode[0]),
        .in_data_i   (in_incoming_data),
        .in_vc_i     (in_incoming_vc),
        .in_valid_i  (in_incoming_valid),
        .in_ready_o  (in_incoming_ready),
        .out_data_o  (in_outgoing_data),
        .out_vc_o    (in_outgoing_vc),
        .out_valid_o (in_outgoing_valid),
        .out_ready_i (in_outgoing_ready),
        .full_o      (in_fifo_full)
    );

    spine_vc_path #(.DWIDTH(DWIDTH), .FIFO_DEPTH(FIFO_DEPTH), .NUM_VC(NUM_VC), .VCW(VCW)) u_out (
        .clk         (clk),
        .reset       (reset),
        .en_i        (dir_mode[1]),
        .in_data_i   (out_incoming_data),
        .in_vc_i     (out_incoming_vc),
        .in_valid_i  (out_incoming_valid),
        .in_ready_o  (out_incoming_ready),
        .out_data_o  (out_outgoing_data),
        .out_vc_o    (out_outgoing_vc),
        .out_valid_o (out_outgoing_valid),
        .out_ready_i (out_outgoing_ready),
        .full_o      (out_fifo_full)
    );
endmodule
